// File: rtl/ifu_prefetch_pkg.sv
// Shared constants and types for the instruction-fetch prefetch unit.
// Widths line up with the core's InstAddrBus / InstBus.
package ifu_prefetch_pkg;

    localparam int          ADDR_W_DEF   = 64;
    localparam int          INST_W_DEF   = 32;
    localparam int          DEPTH_DEF    = 4;
    localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    // What happens to a response strobe in the current cycle.
    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_DROP,
        RSP_PUSH
    } rsp_action_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifu_inst_fifo.sv
// Small in-order FIFO with synchronous flush and occupancy count.
// Head entry is visible combinationally so a queued item can be consumed at once.
module ifu_inst_fifo
    import ifu_prefetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic                        flush_i,
    input  logic                        push_i,
    input  logic [WIDTH-1:0]            push_data_i,
    input  logic                        pop_i,
    output logic [WIDTH-1:0]            pop_data_o,
    output logic [cnt_width(DEPTH)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i & (count_q != '0);
    assign do_push = push_i & (count_q != CNT_W'(DEPTH));

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i && !srst) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch front end: sequential PC generation with credit-limited
// prefetch, in-order response queue and redirect handling with stale-response discard.
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INST_W   = INST_W_DEF,
    parameter int                DEPTH    = DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              imem_rsp_err,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_err
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int Q_W   = ADDR_W + INST_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  discard_q, discard_d;

    logic              req_fire;
    rsp_action_e       rsp_act;
    logic              rsp_seen;
    logic [CNT_W:0]    in_use;

    logic [ADDR_W-1:0] tag_head;
    logic [CNT_W-1:0]  tag_count_unused;
    logic [Q_W-1:0]    q_head;
    logic [CNT_W-1:0]  q_count;
    logic              q_pop;
    logic              redirect_lsb_unused;

    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // Credit covers both in-flight requests and buffered instructions, so the
    // queue can always absorb every outstanding response.
    assign in_use         = {1'b0, outst_q} + {1'b0, q_count};
    assign imem_req_valid = ~rst_n & (in_use < (CNT_W + 1)'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // A strobe with nothing outstanding is a memory protocol error and is ignored.
    always_comb begin
        rsp_act = RSP_NONE;
        if (imem_rsp_valid && outst_q != '0) begin
            if (discard_q != '0 || redirect_valid) begin
                rsp_act = RSP_DROP;
            end else begin
                rsp_act = RSP_PUSH;
            end
        end
    end

    assign rsp_seen = (rsp_act != RSP_NONE);

    always_comb begin
        outst_d = outst_q;
        if (req_fire && !rsp_seen) begin
            outst_d = outst_q + CNT_W'(1);
        end else if (!req_fire && rsp_seen) begin
            outst_d = outst_q - CNT_W'(1);
        end
    end

    // Every request still unanswered after a redirect belongs to the old stream.
    always_comb begin
        discard_d = discard_q;
        pc_d      = pc_q;
        if (redirect_valid) begin
            discard_d = outst_d;
            pc_d      = {redirect_pc[ADDR_W-1:2], 2'b00};
        end else begin
            if (rsp_seen && discard_q != '0) begin
                discard_d = discard_q - CNT_W'(1);
            end
            if (req_fire) begin
                pc_d = pc_q + ADDR_W'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc_q      <= RESET_PC;
            outst_q   <= '0;
            discard_q <= '0;
        end else begin
            pc_q      <= pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
        end
    end

    // Tags exist only for live requests; stale ones are tracked by discard alone.
    ifu_inst_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk         (clk),
        .srst        (rst_n),
        .flush_i     (redirect_valid),
        .push_i      (req_fire & ~redirect_valid),
        .push_data_i (pc_q),
        .pop_i       (rsp_act == RSP_PUSH),
        .pop_data_o  (tag_head),
        .count_o     (tag_count_unused)
    );

    assign q_pop = id_valid & id_ready & ~redirect_valid;

    ifu_inst_fifo #(
        .WIDTH (Q_W),
        .DEPTH (DEPTH)
    ) u_inst_q (
        .clk         (clk),
        .srst        (rst_n),
        .flush_i     (redirect_valid),
        .push_i      (rsp_act == RSP_PUSH),
        .push_data_i ({tag_head, imem_rsp_data, imem_rsp_err}),
        .pop_i       (q_pop),
        .pop_data_o  (q_head),
        .count_o     (q_count)
    );

    assign id_valid = (q_count != '0);

    always_comb begin
        id_pc   = '0;
        id_inst = '0;
        id_err  = 1'b0;
        if (id_valid) begin
            {id_pc, id_inst, id_err} = q_head;
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: randomized memory latency, stalls and
// redirects against an expected in-order instruction stream.
module tb_ifu_prefetch;

    localparam logic [63:0] RST_PC  = 64'h8000_0000;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, imem_req_valid, imem_req_ready, imem_rsp_valid, imem_rsp_err;
    logic [63:0] imem_req_addr, redirect_pc, id_pc;
    logic [31:0] imem_rsp_data, id_inst;
    logic        redirect_valid, id_valid, id_ready, id_err;

    ifu_prefetch #(.ADDR_W(64), .INST_W(32), .DEPTH(4), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst), .id_err(id_err)
    );

    // Second instance exercising PC wrap and redirect alignment.
    logic        w_rst, w_req_valid, w_ready, w_rsp_valid, w_redirect, w_id_valid, w_id_ready, w_id_err;
    logic [63:0] w_req_addr, w_redirect_pc, w_id_pc;
    logic [31:0] w_id_inst;

    ifu_prefetch #(.ADDR_W(64), .INST_W(32), .DEPTH(4), .RESET_PC(WRAP_PC)) u_wrap (
        .clk(clk), .rst_n(w_rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_ready), .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(32'h0), .imem_rsp_err(1'b0),
        .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
        .id_valid(w_id_valid), .id_ready(w_id_ready), .id_pc(w_id_pc), .id_inst(w_id_inst), .id_err(w_id_err)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [63:0] pc; logic [31:0] inst; logic err; } exp_t;
    typedef struct packed { logic [63:0] addr; int due; } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    int          cyc = 0;
    int          lat_min = 1, lat_max = 1, last_due = 0;
    int          granted = 0, returned = 0;
    logic [63:0] model_pc = RST_PC;
    bit          rand_mode = 0;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0013;
    endfunction

    function automatic logic err_of(input logic [63:0] a);
        return a[6:2] == 5'd2;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory responder and random stimulus, driven just after each rising edge.
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        if (!rst_n && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            pend_t p;
            p = pend_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(p.addr);
            imem_rsp_err   = err_of(p.addr);
        end
        if (rand_mode) begin
            imem_req_ready = ($urandom_range(0, 9) < 7);
            id_ready       = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
        end
    end

    // Stimulus side of the scoreboard: expected stream and fetch-PC model.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_q.delete();
            pend_q.delete();
            model_pc = RST_PC;
            last_due = 0;
            granted  = 0;
            returned = 0;
        end else begin
            if (imem_rsp_valid) begin
                checks++;
                assert (granted > returned) else begin
                    errors++;
                    $display("FAIL rsp_protocol granted=%0d returned=%0d", granted, returned);
                end
                returned++;
            end
            if (imem_req_valid && imem_req_ready) begin
                int due;
                check("req_addr", imem_req_addr, model_pc);
                due = cyc + $urandom_range(lat_min, lat_max);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend_q.push_back('{addr: imem_req_addr, due: due});
                granted++;
                if (!redirect_valid)
                    exp_q.push_back('{pc: model_pc, inst: inst_of(model_pc), err: err_of(model_pc)});
            end
            if (redirect_valid) begin
                exp_q.delete();
                model_pc = {redirect_pc[63:2], 2'b00};
            end else if (imem_req_valid && imem_req_ready) begin
                model_pc = model_pc + 64'd4;
            end
        end
    end

    // Monitor: compares each delivered instruction with the expected stream.
    always @(negedge clk) begin
        if (!rst_n) begin
            if (!id_valid) begin
                check("idle_zero", {id_pc, id_inst, id_err}, '0);
            end else if (id_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious id_pc=%0h required=none", id_pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("id_pc", id_pc, e.pc);
                    check("id_inst", id_inst, e.inst);
                    check("id_err", id_err, e.err);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        imem_req_ready = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic [63:0] wg;
        rst_n = 1'b1; imem_req_ready = 1'b0; id_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
        w_rst = 1'b1; w_ready = 1'b1; w_id_ready = 1'b1; w_rsp_valid = 1'b0;
        w_redirect = 1'b0; w_redirect_pc = '0;

        // Reset state, then streaming with 1-cycle memory.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_id", {id_valid, id_pc, id_inst, id_err}, '0);
        @(posedge clk); #1;
        rst_n = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b1;
        @(negedge clk);
        check("first_grant", {imem_req_valid, imem_req_addr}, {1'b1, RST_PC});
        @(negedge clk);
        check("no_bypass", id_valid, 1'b0);
        @(negedge clk);
        check("first_out", {id_valid, id_pc, id_err}, {1'b1, RST_PC, 1'b0});
        @(negedge clk);
        check("second_out", {id_valid, id_pc, id_err}, {1'b1, RST_PC + 64'd4, 1'b0});
        @(negedge clk);
        check("third_out", {id_valid, id_pc, id_err}, {1'b1, RST_PC + 64'd8, 1'b1});

        // Decode stalled: credit limits fetch to DEPTH.
        do_reset();
        rst_n = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) n++;
        end
        check("stall_grants", n, 4);
        check("stall_req_valid", imem_req_valid, 1'b0);
        @(posedge clk); #1;
        id_ready = 1'b1;
        n = 0;
        while (n < 10 && !(imem_req_valid && imem_req_ready)) begin
            @(negedge clk);
            if (!(imem_req_valid && imem_req_ready)) n++;
        end
        check("resume_addr", {imem_req_valid, imem_req_addr}, {1'b1, RST_PC + 64'd16});
        repeat (10) @(posedge clk);

        // 3-cycle memory, two in flight, redirect.
        do_reset();
        lat_min = 3; lat_max = 3;
        rst_n = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
        @(posedge clk); #1;
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!id_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("redir_out", {id_valid, id_pc, id_inst}, {1'b1, 64'h8000_1000, inst_of(64'h8000_1000)});

        // Randomized traffic.
        lat_min = 1; lat_max = 4;
        rand_mode = 1;
        repeat (3000) @(posedge clk);
        #1;
        rand_mode = 0;
        imem_req_ready = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("drain", exp_q.size(), 0);

        // PC wrap and redirect alignment on the second instance.
        @(posedge clk); #1;
        w_rst = 1'b0;
        @(negedge clk);
        check("wrap_addr0", {w_req_valid, w_req_addr}, {1'b1, WRAP_PC});
        wg = {63'b0, w_req_valid & w_ready};
        @(posedge clk); #1;
        w_rsp_valid = wg[0];
        @(negedge clk);
        check("wrap_addr1", {w_req_valid, w_req_addr}, {1'b1, 64'h0});
        wg = {63'b0, w_req_valid & w_ready};
        @(posedge clk); #1;
        w_rsp_valid = wg[0]; w_redirect = 1'b1; w_redirect_pc = 64'h8000_0003;
        @(negedge clk);
        wg = {63'b0, w_req_valid & w_ready};
        @(posedge clk); #1;
        w_rsp_valid = wg[0]; w_redirect = 1'b0;
        @(negedge clk);
        check("wrap_redirect", {w_req_valid, w_req_addr}, {1'b1, 64'h8000_0000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Instruction-fetch front end that drives the core's `inst`/`pc` ROM path from a variable-latency instruction memory.
- Generates sequential PCs, keeps up to DEPTH requests in flight, and buffers returned instructions in a small in-order queue.
- Presents instructions to the IF/ID boundary with a valid/ready handshake.
- Handles PC redirects (branch/jump from later stages): flushes queued instructions and discards stale in-flight responses.

Parameters:
- ADDR_W, 64, PC / address width.
- INST_W, 32, instruction width.
- DEPTH, 4, max in-flight requests plus buffered instructions (power of 2, >=2).
- RESET_PC, 64'h8000_0000, first fetch address after reset.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  synchronous, active-high reset (asserted = 1).
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  memory grant; handshake = valid & ready.
- imem_req_addr  out  ADDR_W  fetch address (= current PC).
- imem_rsp_valid  in  1  response strobe, in request order, >=1 cycle after grant.
- imem_rsp_data  in  INST_W  instruction word.
- imem_rsp_err  in  1  access fault for this response.
- redirect_valid  in  1  PC redirect strobe.
- redirect_pc  in  ADDR_W  new fetch address.
- id_valid  out  1  instruction available to decode.
- id_ready  in  1  decode accepts; handshake = valid & ready.
- id_pc  out  ADDR_W  PC of head instruction.
- id_inst  out  INST_W  head instruction.
- id_err  out  1  fault flag of head instruction.

Behaviour:
- Reset (rst_n=1):
  - pc=RESET_PC; outstanding=0, discard=0; queue empty.
  - imem_req_valid=0, id_valid=0, id_pc=0, id_inst=0, id_err=0.
- Credit rule:
  - imem_req_valid = (outstanding + queue_count < DEPTH) & ~rst_n.
  - outstanding counts all granted, unreturned requests, live and stale.
  - The credit rule guarantees the queue never overflows.
- Request bus:
  - Request/grant style; valid and addr may change before a grant (no stability rule).
  - imem_req_addr = pc.
  - On grant: pc <= pc+4, modulo 2^ADDR_W (wraps to 0).
- Outstanding counter: next = outstanding + req_fire - imem_rsp_valid. It never exceeds DEPTH.
- Response:
  - If discard>0: drop the response and decrement discard.
  - Otherwise push {pc_tag, data, err} into the queue. pc_tag comes from an internal DEPTH-entry in-order address FIFO written on grant.
- Latency:
  - Grant at cycle T, response at T+k (k>=1), id_valid at T+k+1 at the earliest.
  - There is no response-to-output bypass.
- Output:
  - id_valid = queue non-empty.
  - id_pc/id_inst/id_err = head entry, or 0 when empty.
  - Pop on id handshake.
  - Push and pop in the same cycle are both performed.
- Redirect (redirect_valid=1), highest priority:
  - The queue is flushed and any pop this cycle is ignored.
  - pc <= {redirect_pc[ADDR_W-1:2],2'b00}.
  - discard <= outstanding_next, so a grant this cycle counts as stale and a response this cycle is dropped, not pushed.
  - First request to the new PC can be granted the following cycle.
  - The address FIFO is flushed in step with discard, so tags stay aligned.
- Back-to-back redirects: the later one wins. discard is recomputed from outstanding_next, never accumulated twice.
- Error responses:
  - Delivered like normal instructions with id_err=1.
  - Fetch continues sequentially; the block takes no action of its own.
- Protocol violations: imem_rsp_valid with outstanding==0 is ignored. The bench flags it with an assertion.
- Reset mid-operation: all state returns to reset values next edge. Responses arriving after reset release for pre-reset requests are the memory's responsibility (memory reset together).

Decomposition:
- Shared package/defines:
  - RESET_PC default.
  - NOP encoding 32'h0000_0013.
  - Width constants (ADDR_W/INST_W aligned with existing InstAddrBus/InstBus).
- One sub-module: ifu_inst_fifo.
  - Synchronous DEPTH-entry FIFO with flush, count, push/pop, registered storage.
  - Instantiated twice: address-tag FIFO and instruction queue.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle response, id_ready=1:
  - First grant is in the first cycle after reset deasserts.
  - id_valid rises 2 cycles later with id_pc=0x8000_0000, then 0x8000_0004 and 0x8000_0008 on consecutive cycles.
- id_ready=0 held, 1-cycle memory:
  - Exactly 4 grants (0x8000_0000..0x8000_000C), then imem_req_valid=0.
  - Raise id_ready: instructions drain in order and fetch resumes at 0x8000_0010.
- 3-cycle memory latency, 2 requests outstanding, redirect to 0x8000_1000:
  - Next 2 responses are dropped.
  - The next id_valid carries id_pc=0x8000_1000 with that response's data.
- Redirect in the same cycle as a grant and an imem_rsp_valid:
  - Both are treated as stale (discard correct).
  - No instruction from the old stream ever reaches id_valid.
- Response with imem_rsp_err=1 for PC 0x8000_0008: id_err=1 with id_pc=0x8000_0008; neighbours have id_err=0.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC: the second request address is 0x0. A redirect_pc of 0x8000_0003 fetches 0x8000_0000.
